i2s_transmitter: RTL

//  Output end of the channel strip. Takes processed stereo 16-bit signed

---
 rtl/i2s_transmitter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/i2s_transmitter.sv
// Philips I2S serialiser with a one-pair holding register and internal BCLK/LRCLK generation.
// Missing samples at a frame boundary are replaced by a silent (all-zero) frame.
module i2s_transmitter #(
    parameter int W       = 16,
    parameter int SLOT    = 32,
    parameter int CLK_DIV = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] sampleInL,
    input  logic [W-1:0] sampleInR,
    input  logic         sampleValid,
    output logic         sampleReady,
    output logic         bclk,
    output logic         lrclk,
    output logic         sdata,
    output logic         frameStart,
    output logic         underflow
);

    localparam int NB  = 2 * SLOT;
    localparam int BW  = $clog2(NB);
    localparam int DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PAD = SLOT - W;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(NB - 1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);
    localparam logic [BW-1:0] SLOT_IDX = BW'(SLOT);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic          bclk_q, bclk_d;
    logic          lrclk_q, lrclk_d;
    logic          sdata_q, sdata_d;
    logic [NB-1:0] frame_q, frame_d;
    logic [W-1:0]  hold_l_q, hold_l_d;
    logic [W-1:0]  hold_r_q, hold_r_d;
    logic          hold_full_q, hold_full_d;
    logic          ready_q, ready_d;
    logic          frame_start_q, frame_start_d;
    logic          underflow_q, underflow_d;
    logic          div_tick;
    logic          accept;

    always_comb begin
        div_cnt_d     = div_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        bclk_d        = bclk_q;
        lrclk_d       = lrclk_q;
        sdata_d       = sdata_q;
        frame_d       = frame_q;
        hold_l_d      = hold_l_q;
        hold_r_d      = hold_r_q;
        hold_full_d   = hold_full_q;
        frame_start_d = 1'b0;
        underflow_d   = 1'b0;

        div_tick  = (div_cnt_q == DIV_LAST);
        div_cnt_d = div_tick ? '0 : div_cnt_q + 1'b1;
        if (div_tick) begin
            bclk_d = ~bclk_q;
        end

        // Everything visible to the DAC changes on the falling BCLK edge only.
        if (div_tick && bclk_q) begin
            bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
            frame_d   = {frame_q[NB-2:0], 1'b0};
            if (bit_cnt_d == BIT_ONE) begin
                frame_start_d = 1'b1;
                if (hold_full_q) begin
                    frame_d     = {hold_l_q, {PAD{1'b0}}, hold_r_q, {PAD{1'b0}}};
                    hold_full_d = 1'b0;
                end else begin
                    frame_d     = '0;
                    underflow_d = 1'b1;
                end
            end
            lrclk_d = (bit_cnt_d >= SLOT_IDX);
            sdata_d = frame_d[NB-1];
        end

        // A pair accepted on an underflow-load cycle waits for the next frame.
        accept = sampleValid && ready_q;
        if (accept) begin
            hold_l_d    = sampleInL;
            hold_r_d    = sampleInR;
            hold_full_d = 1'b1;
        end
        ready_d = ~hold_full_d;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_cnt_q     <= '0;
            bit_cnt_q     <= '0;
            bclk_q        <= 1'b0;
            lrclk_q       <= 1'b0;
            sdata_q       <= 1'b0;
            frame_q       <= '0;
            hold_l_q      <= '0;
            hold_r_q      <= '0;
            hold_full_q   <= 1'b0;
            ready_q       <= 1'b1;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            bclk_q        <= bclk_d;
            lrclk_q       <= lrclk_d;
            sdata_q       <= sdata_d;
            frame_q       <= frame_d;
            hold_l_q      <= hold_l_d;
            hold_r_q      <= hold_r_d;
            hold_full_q   <= hold_full_d;
            ready_q       <= ready_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
        end
    end

    assign sampleReady = ready_q;
    assign bclk        = bclk_q;
    assign lrclk       = lrclk_q;
    assign sdata       = sdata_q;
    assign frameStart  = frame_start_q;
    assign underflow   = underflow_q;

endmodule
